aes_enc_iter_core: RTL and testbench



---
 rtl/aes_pkg.sv | 83 ++++++++
 rtl/aes_enc_iter_core_shiftrows.sv | 29 ++
 rtl/aes_enc_iter_core.sv | 159 +++++++++++++++
 tb/tb_aes_enc_iter_core.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES-128 encryption core:
//   - `TEXT_WIDTH : state / key width macro (128)
//   - state_e     : FSM encoding (IDLE, ROUND, DONE)
//   - NR          : number of rounds (10, fixed for AES-128)
//   - RCON        : key-schedule round constants
//   - SBOX        : forward S-box table and sbox() lookup
//   - xtime(), mix_column() : GF(2^8) helpers for MixColumns (poly 0x11b)
//   - rcon()      : round-number to round-constant lookup
// Optional build macro used by the core: AES_ENC_BACK2BACK_EN.
// ---------------------------------------------------------------------------
`ifndef TEXT_WIDTH
`define TEXT_WIDTH 128
`endif

package aes_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic [3:0] NR = 4'd10;

   localparam logic [0:9][7:0] RCON = {
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Element 0 is the leftmost byte, so SBOX[b] is the substitution of b.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   // Rounds are numbered 1..NR; anything else yields 0 (never used).
   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      logic [3:0] idx;
      idx = rnd - 4'd1;
      if (rnd >= 4'd1 && rnd <= NR) return RCON[idx];
      else                          return 8'h00;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // One column, row 0 in bits [31:24]; {02,03,01,01} circulant.
   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] r0, r1, r2, r3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      r0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
      r1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
      r2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
      r3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
      return {r0, r1, r2, r3};
   endfunction

endpackage

// File: rtl/aes_enc_iter_core_shiftrows.sv
// ---------------------------------------------------------------------------
// aes_enc_iter_core_shiftrows
// Combinational forward ShiftRows. Byte k occupies bits [127-8k -: 8],
// column-major (k = 4*col + row); row r is rotated left by r columns.
// Ports:
//   in_state  : state before ShiftRows
//   out_state : state after ShiftRows
// ---------------------------------------------------------------------------
module aes_enc_iter_core_shiftrows
   import aes_pkg::*;
(
   input  logic [`TEXT_WIDTH-1:0] in_state,
   output logic [`TEXT_WIDTH-1:0] out_state
);

   // Output byte i is taken from input byte SR_MAP[i].
   localparam int SR_MAP [16] = '{0, 5, 10, 15, 4, 9, 14, 3,
                                  8, 13, 2, 7, 12, 1, 6, 11};

   always_comb begin
      // NOTE: a full default before the loop keeps every bit assigned on
      // every pass, so no latch can be inferred.
      out_state = '0;
      for (int i = 0; i < 16; i++) begin
         out_state[127-8*i -: 8] = in_state[127-8*SR_MAP[i] -: 8];
      end
   end

endmodule

// File: rtl/aes_enc_iter_core.sv
// ---------------------------------------------------------------------------
// aes_enc_iter_core
// Iterative AES-128 encryption: one round per clock, round keys expanded on
// the fly. Accept edge loads plaintext^key; ten ROUND cycles later the
// ciphertext is registered on cyphertext_o with out_valid high.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   in_valid / in_ready     : plaintext + key handshake
//   plaintext_i, key_i      : input block and cipher key
//   out_valid / out_ready   : ciphertext handshake
//   cyphertext_o            : registered ciphertext, stable while stalled
// Build option: define AES_ENC_BACK2BACK_EN to let DONE accept the next
// block in the same cycle as the output handshake (11-cycle throughput
// instead of 12).
// ---------------------------------------------------------------------------
module aes_enc_iter_core
   import aes_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [`TEXT_WIDTH-1:0] plaintext_i,
   input  logic [`TEXT_WIDTH-1:0] key_i,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [`TEXT_WIDTH-1:0] cyphertext_o
);

   state_e                 state;
   logic [3:0]             round;
   logic [`TEXT_WIDTH-1:0] state_reg;
   logic [`TEXT_WIDTH-1:0] rk_reg;

   logic [`TEXT_WIDTH-1:0] sb_state;
   logic [`TEXT_WIDTH-1:0] sr_state;
   logic [`TEXT_WIDTH-1:0] mc_state;
   logic [`TEXT_WIDTH-1:0] next_rk;
   logic [`TEXT_WIDTH-1:0] round_out;
   logic [`TEXT_WIDTH-1:0] final_out;

   // ---------------- handshake decode ----------------
`ifdef AES_ENC_BACK2BACK_EN
   assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
`else
   assign in_ready = (state == IDLE);
`endif

   // ---------------- round datapath ----------------
   always_comb begin
      sb_state = '0;
      for (int k = 0; k < 16; k++) begin
         sb_state[127-8*k -: 8] = sbox(state_reg[127-8*k -: 8]);
      end
   end

   aes_enc_iter_core_shiftrows u_shiftrows (
      .in_state  (sb_state),
      .out_state (sr_state)
   );

   always_comb begin
      mc_state = '0;
      for (int c = 0; c < 4; c++) begin
         mc_state[127-32*c -: 32] = mix_column(sr_state[127-32*c -: 32]);
      end
   end

   // Key schedule: one AES-128 expansion step per round.
   always_comb begin
      logic [31:0] w0, w1, w2, w3, temp;
      logic [31:0] n0, n1, n2, n3;
      w0   = rk_reg[127:96];
      w1   = rk_reg[95:64];
      w2   = rk_reg[63:32];
      w3   = rk_reg[31:0];
      temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rcon(round), 24'h000000};
      n0   = w0 ^ temp;
      n1   = w1 ^ n0;
      n2   = w2 ^ n1;
      n3   = w3 ^ n2;
      next_rk = {n0, n1, n2, n3};
   end

   // The last round skips MixColumns.
   assign round_out = mc_state ^ next_rk;
   assign final_out = sr_state ^ next_rk;

   // ---------------- control + state registers ----------------
   always_ff @(posedge clk) begin
      // NOTE: every register here is assigned with <= so all updates use the
      // values from before the edge, independent of statement order.
      if (!rst_n) begin
         // NOTE: the datapath registers are cleared too, so an aborted block
         // leaves no key or plaintext residue visible after reset.
         state        <= IDLE;
         round        <= 4'd0;
         state_reg    <= '0;
         rk_reg       <= '0;
         out_valid    <= 1'b0;
         cyphertext_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state_reg <= plaintext_i ^ key_i;
                  rk_reg    <= key_i;
                  round     <= 4'd1;
                  state     <= ROUND;
               end
            end

            ROUND: begin
               if (round == NR) begin
                  state_reg    <= final_out;
                  rk_reg       <= next_rk;
                  cyphertext_o <= final_out;
                  out_valid    <= 1'b1;
                  round        <= 4'd0;
                  state        <= DONE;
               end else if (round > NR || round == 4'd0) begin
                  // Unreachable counter values fall back to IDLE.
                  round <= 4'd0;
                  state <= IDLE;
               end else begin
                  state_reg <= round_out;
                  rk_reg    <= next_rk;
                  round     <= round + 4'd1;
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
`ifdef AES_ENC_BACK2BACK_EN
                  if (in_valid) begin
                     state_reg <= plaintext_i ^ key_i;
                     rk_reg    <= key_i;
                     round     <= 4'd1;
                     state     <= ROUND;
                  end else begin
                     state <= IDLE;
                  end
`else
                  state <= IDLE;
`endif
               end
            end

            default: begin
               round <= 4'd0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_enc_iter_core.sv
// ---------------------------------------------------------------------------
// tb_aes_enc_iter_core
// Scoreboard bench for aes_enc_iter_core. The stimulus process pushes the
// expected ciphertext when it offers a block; a monitor on the falling edge
// pops and compares on every output handshake, checks accept-to-valid
// latency, output stability under backpressure and back-to-back spacing.
// ---------------------------------------------------------------------------
module tb_aes_enc_iter_core;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] plaintext_i;
   logic [127:0] key_i;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] cyphertext_o;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

`ifdef AES_ENC_BACK2BACK_EN
   localparam int EXP_GAP = 11;
`else
   localparam int EXP_GAP = 12;
`endif

   int           checks = 0;
   int           errors = 0;
   int           cyc    = 0;
   logic [127:0] exp_q [$];
   int           acc_q [$];
   logic         prev_ov = 1'b0;
   logic [127:0] held;
   int           last_rise;
   logic         gap_armed = 1'b0;
   logic         gap_seen  = 1'b0;

   aes_enc_iter_core dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .plaintext_i  (plaintext_i),
      .key_i        (key_i),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .cyphertext_o (cyphertext_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         // Sampled values here are the ones the next rising edge will see.
         if (in_valid && in_ready) acc_q.push_back(cyc + 1);
         if (out_valid && !prev_ov) begin
            held = cyphertext_o;
            if (acc_q.size() > 0) check("latency", 128'(cyc - acc_q.pop_front()), 128'd10);
            else                  check("latency_no_accept", 128'd1, 128'd0);
            if (gap_armed) begin
               if (gap_seen) check("b2b_gap", 128'(cyc - last_rise), 128'(EXP_GAP));
               gap_seen = 1'b1;
            end
            last_rise = cyc;
         end
         if (out_valid && !out_ready) begin
            check("hold_data", cyphertext_o, held);
            check("hold_in_ready", {127'd0, in_ready}, 128'd0);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() > 0) check("ciphertext", cyphertext_o, exp_q.pop_front());
            else                  check("unexpected_output", cyphertext_o, 128'd0 ^ ~cyphertext_o);
         end
         prev_ov = out_valid;
      end else begin
         prev_ov = 1'b0;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      acc_q.delete();
      exp_q.delete();
   endtask

   // Called at posedge+#1; returns at posedge+#1 just after the accept edge.
   task automatic send(input logic [127:0] k, input logic [127:0] p, input logic [127:0] ct);
      logic acc;
      int   n;
      exp_q.push_back(ct);
      in_valid    = 1'b1;
      key_i       = k;
      plaintext_i = p;
      n           = 0;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         n++;
      end while (!acc && n < 100);
      if (!acc) check("accept_timeout", 128'd0, 128'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_timeout", 128'(exp_q.size()), 128'd0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      key_i       = '0;
      plaintext_i = '0;
      repeat (3) @(posedge clk);
      #1;
      do_reset();

      check("reset_in_ready", {127'd0, in_ready}, 128'd1);
      check("reset_out_valid", {127'd0, out_valid}, 128'd0);
      check("reset_cyphertext", cyphertext_o, 128'd0);

      // FIPS-197 C.1
      send(C1_KEY, C1_PT, C1_CT);
      drain();

      // App. B with in_valid pulses and changing plaintext during ROUND
      send(B_KEY, B_PT, B_CT);
      for (int i = 0; i < 4; i++) begin
         in_valid    = 1'b1;
         plaintext_i = {$urandom, $urandom, $urandom, $urandom};
         key_i       = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      drain();

      // Backpressure: 20 stalled cycles with ignored in_valid activity
      out_ready = 1'b0;
      send(C1_KEY, C1_PT, C1_CT);
      for (int n = 0; n < 40 && !out_valid; n++) begin
         @(posedge clk); #1;
      end
      check("bp_out_valid", {127'd0, out_valid}, 128'd1);
      for (int i = 0; i < 20; i++) begin
         in_valid    = i[0];
         plaintext_i = B_PT;
         key_i       = B_KEY;
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_out_valid", {127'd0, out_valid}, 128'd0);
      check("bp_release_in_ready", {127'd0, in_ready}, 128'd1);
      drain();

      // Reset while round 5 is pending
      send(B_KEY, B_PT, B_CT);
      repeat (4) @(posedge clk);
      #1;
      do_reset();
      check("abort_out_valid", {127'd0, out_valid}, 128'd0);
      check("abort_cyphertext", cyphertext_o, 128'd0);
      check("abort_in_ready", {127'd0, in_ready}, 128'd1);
      send(C1_KEY, C1_PT, C1_CT);
      drain();

      // Back-to-back blocks with the sink always ready
      gap_armed = 1'b1;
      gap_seen  = 1'b0;
      send(C1_KEY, C1_PT, C1_CT);
      send(B_KEY, B_PT, B_CT);
      drain();
      check("b2b_both_seen", {127'd0, gap_seen}, 128'd1);
      gap_armed = 1'b0;

      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
